dac_frame_sequencer: RTL and testbench

Sequences serial loading of one DAC code word and the DAC update/settle cycle that follows it. Bits arrive MSB-first on a strobed serial input and are framed by a start pulse. Each frame ends with an even-parity bit. A frame that passes parity commits to the DAC code register, raises a one-cycle load strobe and holds busy for a fixed settle window. The block sits between the ui_in pin map and the DAC data/convert registers in the top level.

---
 rtl/dac_ctrl_pkg.sv | 21 ++
 rtl/dac_serial_in.sv | 46 ++++
 rtl/dac_frame_sequencer.sv | 119 +++++++++++
 tb/tb_dac_frame_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_ctrl_pkg.sv
// dac_ctrl_pkg: shared state encoding, default sizing and parity helper for the DAC frame sequencer
//   No ports; imported by dac_serial_in and dac_frame_sequencer.
package dac_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SETTLE_CYC  = 16;
    localparam int DEF_TIMEOUT_CYC = 255;

    // XOR of all bits; 1 means an even-parity frame is corrupt.
    // Callers zero-extend to 64 bits, which leaves the XOR unchanged.
    function automatic logic parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dac_serial_in.sv
// dac_serial_in: MSB-first serial word capture with bit counter and frame-complete/parity detection
//   clk, rst_n    : clock, synchronous active-low reset
//   clr           : restart capture (clears shift register and bit count)
//   en            : accept sdi this cycle
//   sdi           : serial bit, data MSB first, parity bit last
//   frame_full    : this cycle's accepted bit is the (DATA_W+1)th (parity) bit
//   data          : data bits of the frame completing this cycle
//   par_err       : XOR over all DATA_W+1 frame bits including the incoming one
module dac_serial_in
    import dac_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              sdi,
    output logic              frame_full,
    output logic [DATA_W-1:0] data,
    output logic              par_err
);
    localparam int CW = $clog2(DATA_W + 2);

    // The frame is judged on the edge that samples the parity bit, so the
    // (DATA_W+1)-bit frame is the stored data bits plus the live sdi bit.
    logic [DATA_W-1:0] sr;
    logic [DATA_W:0]   frame;
    logic [CW-1:0]     cnt;

    assign frame      = {sr, sdi};
    assign data       = sr;
    assign par_err    = parity(64'(frame));
    assign frame_full = en && cnt == CW'(DATA_W);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (en) begin
            sr  <= frame[DATA_W-1:0];
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: frames a serial DAC code word, checks parity, commits it and times the settle window
//   clk, rst_n   : clock, synchronous active-low reset
//   frame_start  : start/restart a frame (IDLE and SHIFT only)
//   sdi          : serial bit, MSB first, parity bit last
//   sdi_valid    : qualifies sdi
//   dac_code     : committed DAC code
//   dac_load     : one-cycle pulse with a newly committed dac_code
//   busy         : high in SHIFT and SETTLE
//   done         : one-cycle pulse when the settle window ends
//   frame_err    : sticky parity/timeout error, cleared by an accepted frame_start
module dac_frame_sequencer
    import dac_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              sdi,
    input  logic              sdi_valid,
    output logic [DATA_W-1:0] dac_code,
    output logic              dac_load,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_t            state;
    logic [TW-1:0]     to_cnt;
    logic [SW-1:0]     st_cnt;
    logic              clr;
    logic              en;
    logic              frame_full;
    logic              par_err;
    logic [DATA_W-1:0] data;

    // frame_start wins over sdi_valid, so a restarting cycle never shifts.
    assign clr = frame_start && (state == ST_IDLE || state == ST_SHIFT);
    assign en  = state == ST_SHIFT && sdi_valid && !frame_start;

    dac_serial_in #(.DATA_W(DATA_W)) u_serial_in (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .en         (en),
        .sdi        (sdi),
        .frame_full (frame_full),
        .data       (data),
        .par_err    (par_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dac_code  <= '0;
            dac_load  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            to_cnt    <= '0;
            st_cnt    <= '0;
        end else begin
            dac_load <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state     <= ST_SHIFT;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                        to_cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (frame_start) begin
                        to_cnt <= '0;
                    end else if (sdi_valid) begin
                        to_cnt <= '0;
                        if (frame_full && !par_err) begin
                            dac_code <= data;
                            dac_load <= 1'b1;
                            state    <= ST_SETTLE;
                            st_cnt   <= SW'(1);
                        end else if (frame_full) begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                        end
                    // Abort on the edge where the idle count would reach TIMEOUT_CYC.
                    end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (st_cnt == SW'(SETTLE_CYC)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        st_cnt <= st_cnt + SW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb_dac_frame_sequencer: directed self-checking bench for dac_frame_sequencer
module tb_dac_frame_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       sdi = 1'b0;
    logic       sdi_valid = 1'b0;
    logic [7:0] dac_code;
    logic       dac_load;
    logic       busy;
    logic       done;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    dac_frame_sequencer #(.DATA_W(8), .SETTLE_CYC(16), .TIMEOUT_CYC(255)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .sdi         (sdi),
        .sdi_valid   (sdi_valid),
        .dac_code    (dac_code),
        .dac_load    (dac_load),
        .busy        (busy),
        .done        (done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        sdi_valid = 1'b1;
        tick();
        sdi_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            for (int g = 0; g < gap; g++) tick();
        end
        send_bit(p);
    endtask

    // Ticks until done pulses, bounded; n is the tick count.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_code"}, 32'(dac_code), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_load"}, 32'(dac_load), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(frame_err), 32'h0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk_idle_outs("reset");
        rst_n = 1'b1;
        tick();

        // Good frame A5: 16-cycle settle, single done pulse
        start();
        chk("start_busy", 32'(busy), 32'h1);
        send_frame(8'hA5, 1'b0, 0);
        chk("a5_code", 32'(dac_code), 32'hA5);
        chk("a5_load", 32'(dac_load), 32'h1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("a5_settle_busy", 32'(busy), 32'h1);
            chk("a5_settle_load", 32'(dac_load), 32'h0);
            chk("a5_settle_done", 32'(done), 32'h0);
        end
        tick();
        chk("a5_done", 32'(done), 32'h1);
        chk("a5_busy_off", 32'(busy), 32'h0);
        tick();
        chk("a5_done_once", 32'(done), 32'h0);

        // Bad parity: 01 with parity 0
        start();
        send_frame(8'h01, 1'b0, 0);
        chk("bad_err", 32'(frame_err), 32'h1);
        chk("bad_code", 32'(dac_code), 32'hA5);
        chk("bad_load", 32'(dac_load), 32'h0);
        chk("bad_busy", 32'(busy), 32'h0);
        tick();
        chk("bad_err_sticky", 32'(frame_err), 32'h1);
        start();
        chk("restart_err_clr", 32'(frame_err), 32'h0);

        // Gapped frame 3C
        send_frame(8'h3C, 1'b0, 3);
        chk("gap_code", 32'(dac_code), 32'h3C);
        chk("gap_load", 32'(dac_load), 32'h1);
        wait_done(n);
        chk("gap_settle_len", 32'(n), 32'd16);

        // Timeout after 4 bits: still busy after 254 idle cycles, aborted on the 255th
        tick();
        start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        for (int i = 0; i < 254; i++) tick();
        chk("to_edge_busy", 32'(busy), 32'h1);
        chk("to_edge_err", 32'(frame_err), 32'h0);
        tick();
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_err", 32'(frame_err), 32'h1);
        chk("to_code", 32'(dac_code), 32'h3C);

        // Restart mid-frame after 4 bits, then clean 5A
        start();
        chk("rs_err_clr", 32'(frame_err), 32'h0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        start();
        chk("rs_busy", 32'(busy), 32'h1);
        send_frame(8'h5A, 1'b0, 0);
        chk("rs_code", 32'(dac_code), 32'h5A);
        chk("rs_load", 32'(dac_load), 32'h1);

        // Inputs pulsed during SETTLE are ignored
        frame_start = 1'b1;
        sdi_valid = 1'b1;
        sdi = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        frame_start = 1'b0;
        sdi_valid = 1'b0;
        n = 3;
        while (!done && n < 64) begin
            tick();
            n++;
        end
        chk("settle_ign_len", 32'(n), 32'd16);
        chk("settle_ign_code", 32'(dac_code), 32'h5A);
        tick();
        chk("settle_ign_idle", 32'(busy), 32'h0);

        // Odd data count with parity bit 1
        start();
        send_frame(8'h07, 1'b1, 0);
        chk("p1_code", 32'(dac_code), 32'h07);
        chk("p1_load", 32'(dac_load), 32'h1);
        wait_done(n);
        chk("p1_settle_len", 32'(n), 32'd16);
        tick();

        // Reset in the middle of SHIFT
        start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        tick();
        chk_idle_outs("rst_shift");
        rst_n = 1'b1;
        tick();

        // Reset in the middle of SETTLE
        start();
        send_frame(8'hC3, 1'b0, 0);
        chk("c3_code", 32'(dac_code), 32'hC3);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        chk_idle_outs("rst_settle");
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n += int'(done) + int'(dac_load) + int'(busy);
        end
        chk("rst_no_glitch", 32'(n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
